// File: rtl/seq_enc_pkg.sv
// Shared types, widths and helpers for the sequential priority encoder.
package seq_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int unsigned ENC_WIDTH  = 8;
    localparam int unsigned ENC_CODE_W = 3;

    // True when exactly one bit is set; vectors up to 32 bits wide.
    function automatic logic popcount_is_one(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: index of the highest (or lowest) set bit.
module prio_enc8
    import seq_enc_pkg::*;
#(
    parameter int unsigned WIDTH     = ENC_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CODE_W   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic              any_set
);

    // Later matches overwrite earlier ones, so scan order sets the winner.
    always_comb begin
        code    = '0;
        any_set = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/seq_prio_encoder8.sv
// Accepts a multi-hot request vector and emits the index of each set bit in
// priority order, one per output handshake, flagging the final one.
module seq_prio_encoder8
    import seq_enc_pkg::*;
#(
    parameter int unsigned WIDTH     = ENC_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CODE_W   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              zero_drop
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pending;
    logic               r_rdy;
    logic               r_zero_drop;

    logic [CODE_W-1:0]  w_code;
    logic               w_any_set;
    logic               w_last;
    logic               w_in_hs;
    logic               w_out_hs;
    logic [WIDTH-1:0]   w_clr_mask;

    prio_enc8 #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec     (r_pending),
        .code    (w_code),
        .any_set (w_any_set)
    );

    assign w_last     = popcount_is_one(32'(r_pending));
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_clr_mask = WIDTH'(1) << w_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_hs && (in_vec != '0)) w_state_nxt = SERVE;
            SERVE:   if (w_out_hs && w_last)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs come only from r_state/r_pending; no path from in_* to out_*.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_code  = '0;
        out_last  = 1'b0;
        zero_drop = r_zero_drop;
        case (r_state)
            IDLE:  in_ready = r_rdy;
            SERVE: begin
                out_valid = w_any_set;
                out_code  = w_code;
                out_last  = w_last;
            end
            default: ;
        endcase
    end

    // r_rdy keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_rdy       <= 1'b0;
            r_zero_drop <= 1'b0;
        end else begin
            r_rdy       <= 1'b1;
            r_zero_drop <= w_in_hs && (in_vec == '0);
            if (w_in_hs)       r_pending <= in_vec;
            else if (w_out_hs) r_pending <= r_pending & ~w_clr_mask;
        end
    end

endmodule

// File: tb/tb_seq_prio_encoder8.sv
// Bench for seq_prio_encoder8: both priority orders driven in lockstep and
// compared against a set-bit list model of each vector.
module tb_seq_prio_encoder8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_m, out_valid_m, out_last_m, zero_drop_m;
    logic [2:0] out_code_m;
    logic       in_ready_l, out_valid_l, out_last_l, zero_drop_l;
    logic [2:0] out_code_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_prio_encoder8 #(.MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .in_vec    (in_vec),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_code  (out_code_m),
        .out_last  (out_last_m),
        .zero_drop (zero_drop_m)
    );

    seq_prio_encoder8 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_vec    (in_vec),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_code  (out_code_l),
        .out_last  (out_last_l),
        .zero_drop (zero_drop_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!(in_ready_m && in_ready_l) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", 32'(in_ready_m && in_ready_l), 32'd1);
    endtask

    // stall_pct < 0 selects an alternating 1,0,1,0 out_ready pattern.
    task automatic run_vec(input logic [7:0] v, input int stall_pct, input bit busy_junk);
        logic [2:0] em[$];
        logic [2:0] el[$];
        int         n;
        int         cyc;
        bit         rdy;
        bit         tog;
        for (int i = 7; i >= 0; i--) if (v[i]) em.push_back(3'(i));
        for (int i = 0; i < 8; i++)  if (v[i]) el.push_back(3'(i));
        n = em.size();
        wait_ready();
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        @(negedge clk);
        if (busy_junk) in_vec = 8'h80;
        else begin
            in_valid = 1'b0;
            in_vec   = 8'($urandom);
        end
        if (n == 0) begin
            in_valid = 1'b0;
            chk("zero_drop_m", 32'(zero_drop_m), 32'd1);
            chk("zero_drop_l", 32'(zero_drop_l), 32'd1);
            chk("zero_no_out", 32'(out_valid_m | out_valid_l), 32'd0);
            chk("zero_in_ready", 32'(in_ready_m & in_ready_l), 32'd1);
            @(negedge clk);
            chk("zero_drop_pulse", 32'(zero_drop_m | zero_drop_l), 32'd0);
            chk("zero_no_out2", 32'(out_valid_m | out_valid_l), 32'd0);
            return;
        end
        chk("busy_in_ready", 32'(in_ready_m | in_ready_l), 32'd0);
        chk("busy_zero_drop", 32'(zero_drop_m | zero_drop_l), 32'd0);
        cyc = 0;
        tog = 1'b1;
        for (int k = 0; k < n; k++) begin
            while (1) begin
                chk("valid_m", 32'(out_valid_m), 32'd1);
                chk("valid_l", 32'(out_valid_l), 32'd1);
                chk("code_m", 32'(out_code_m), 32'(em[k]));
                chk("code_l", 32'(out_code_l), 32'(el[k]));
                chk("last_m", 32'(out_last_m), 32'(k == n - 1));
                chk("last_l", 32'(out_last_l), 32'(k == n - 1));
                if (n == 1)
                    chk("roundtrip", 32'(8'(1) << out_code_m), 32'(v));
                if (stall_pct < 0) begin
                    rdy = tog;
                    tog = ~tog;
                end else begin
                    rdy = ($urandom_range(0, 99) >= stall_pct);
                end
                out_ready = rdy;
                @(negedge clk);
                cyc++;
                if (rdy || cyc > 400) break;
            end
        end
        if (stall_pct == 0) chk("valid_cycles", 32'(cyc), 32'(n));
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("done_valid", 32'(out_valid_m | out_valid_l), 32'd0);
        chk("done_in_ready", 32'(in_ready_m & in_ready_l), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;

        #3;
        chk("rst_in_ready", 32'(in_ready_m | in_ready_l), 32'd0);
        chk("rst_out_valid", 32'(out_valid_m | out_valid_l), 32'd0);
        chk("rst_out_code", 32'(out_code_m | out_code_l), 32'd0);
        chk("rst_out_last", 32'(out_last_m | out_last_l), 32'd0);
        chk("rst_zero_drop", 32'(zero_drop_m | zero_drop_l), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_m & in_ready_l), 32'd1);

        run_vec(8'h20, 0, 1'b0);
        run_vec(8'b1001_0010, -1, 1'b0);
        run_vec(8'hFF, 0, 1'b0);
        run_vec(8'h00, 0, 1'b0);
        run_vec(8'h0C, 0, 1'b1);
        run_vec(8'h80, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            v = 8'(1) << i;
            run_vec(v, 30, 1'b0);
        end

        // Reset between edges while codes remain pending.
        wait_ready();
        in_valid = 1'b1;
        in_vec   = 8'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_code_m", 32'(out_code_m), 32'd7);
        chk("mid_code_l", 32'(out_code_l), 32'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid_m | out_valid_l), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_m | in_ready_l), 32'd0);
        chk("mid_rst_pending", 32'(u_msb.r_pending | u_lsb.r_pending), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", 32'(in_ready_m & in_ready_l), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_residual", 32'(out_valid_m | out_valid_l), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;

        for (int r = 0; r < 40; r++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v = 8'h00;
            run_vec(v, int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
